// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline hazard controller for a 5-stage RISC-V style core.
//                Handles load-use stalls, branch mispredict flushes, CSR /
//                ecall / mret serialization (drain then redirect) and data
//                memory wait states. Outputs are combinational from the
//                registered FSM state and the current inputs.
//                Optional feature macro: PIPE_STALL_CNT_EN (stall counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_is_csr,
    input  logic        id_is_trap,
    input  logic        ex_memread,
    input  logic [4:0]  ex_wreg,
    input  logic        ex_mispredict,
    input  logic        mem_busy,
    output logic        pc_keep,
    output logic        ifid_keep,
    output logic        ifid_nop,
    output logic        id_keep,
    output logic        id_nop,
    output logic        ex_keep,
    output logic        trap_redirect,
    output logic [2:0]  state_o,
    output logic [31:0] stall_cnt
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        LDUSE = 3'd1,
        DRAIN = 3'd2,
        REDIR = 3'd3,
        MWAIT = 3'd4
    } state_t;

    // The RUN cycle that accepts the CSR already emits the first bubble, so
    // the counter starts one short of DRAIN_CYCLES.
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t     state, state_nxt;
    state_t     resume, resume_nxt;
    logic [2:0] drain_cnt, drain_cnt_nxt;
    logic       trap_lat, trap_lat_nxt;
    logic       load_use;

    assign load_use = ex_memread && (ex_wreg != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_wreg)) ||
                       (id_use_rs2 && (id_rs2 == ex_wreg)));

    assign state_o = state;

    // State, resume, drain counter and trap latch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            resume    <= RUN;
            drain_cnt <= 3'd0;
            trap_lat  <= 1'b0;
        end else begin
            state     <= state_nxt;
            resume    <= resume_nxt;
            drain_cnt <= drain_cnt_nxt;
            trap_lat  <= trap_lat_nxt;
        end
    end

    // Next-state and output decode; priority mem_busy > mispredict > CSR > load-use.
    always_comb begin
        pc_keep       = 1'b0;
        ifid_keep     = 1'b0;
        ifid_nop      = 1'b0;
        id_keep       = 1'b0;
        id_nop        = 1'b0;
        ex_keep       = 1'b0;
        trap_redirect = 1'b0;
        state_nxt     = state;
        resume_nxt    = resume;
        drain_cnt_nxt = drain_cnt;
        trap_lat_nxt  = trap_lat;

        if (state == MWAIT) begin
            // Everything frozen; release cycle still looks like MWAIT.
            pc_keep   = 1'b1;
            ifid_keep = 1'b1;
            id_keep   = 1'b1;
            ex_keep   = 1'b1;
            if (!mem_busy) begin
                state_nxt = resume;
            end
        end else if (mem_busy) begin
            pc_keep    = 1'b1;
            ifid_keep  = 1'b1;
            id_keep    = 1'b1;
            ex_keep    = 1'b1;
            resume_nxt = state;
            state_nxt  = MWAIT;
        end else if (ex_mispredict && (state != REDIR)) begin
            // Flush the wrong-path instructions and abandon any drain.
            ifid_nop      = 1'b1;
            id_nop        = 1'b1;
            drain_cnt_nxt = 3'd0;
            trap_lat_nxt  = 1'b0;
            state_nxt     = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (id_is_csr) begin
                        pc_keep       = 1'b1;
                        ifid_keep     = 1'b1;
                        id_nop        = 1'b1;
                        drain_cnt_nxt = DRAIN_LOAD;
                        trap_lat_nxt  = id_is_trap;
                        state_nxt     = DRAIN;
                    end else if (load_use) begin
                        pc_keep   = 1'b1;
                        ifid_keep = 1'b1;
                        id_nop    = 1'b1;
                        state_nxt = LDUSE;
                    end
                end
                LDUSE: begin
                    // Stalled instruction advances; forwarding covers it.
                    state_nxt = RUN;
                end
                DRAIN: begin
                    pc_keep   = 1'b1;
                    ifid_keep = 1'b1;
                    id_nop    = 1'b1;
                    // Leave once this cycle takes the counter to zero; a zero
                    // preload (DRAIN_CYCLES=1) still spends one DRAIN cycle.
                    if (drain_cnt <= 3'd1) begin
                        drain_cnt_nxt = 3'd0;
                        state_nxt     = REDIR;
                    end else begin
                        drain_cnt_nxt = drain_cnt - 3'd1;
                    end
                end
                REDIR: begin
                    if (trap_lat) begin
                        trap_redirect = 1'b1;
                        ifid_nop      = 1'b1;
                    end
                    trap_lat_nxt = 1'b0;
                    state_nxt    = RUN;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end

        // Outputs are silent for the whole time reset is held.
        if (!rst) begin
            pc_keep       = 1'b0;
            ifid_keep     = 1'b0;
            ifid_nop      = 1'b0;
            id_keep       = 1'b0;
            id_nop        = 1'b0;
            ex_keep       = 1'b0;
            trap_redirect = 1'b0;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count every cycle the PC is held; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 32'h0;
        end else if (pc_keep) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//                followed by randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int DC = 3;

    // Model phase numbers are the architectural state codes.
    localparam int P_RUN   = 0;
    localparam int P_LDUSE = 1;
    localparam int P_DRAIN = 2;
    localparam int P_REDIR = 3;
    localparam int P_MWAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_wreg;
    logic        id_use_rs1, id_use_rs2, id_is_csr, id_is_trap;
    logic        ex_memread, ex_mispredict, mem_busy;
    logic        pc_keep, ifid_keep, ifid_nop, id_keep, id_nop, ex_keep;
    logic        trap_redirect;
    logic [2:0]  state_o;
    logic [31:0] stall_cnt;

    int          tests = 0;
    int          fails = 0;

    // Behavioural model
    int          m_phase;
    int          m_saved;
    int          m_bubbles_left;
    bit          m_trap;
    logic [31:0] m_stalls;
    bit          prev_tr;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(DC)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .id_is_csr     (id_is_csr),
        .id_is_trap    (id_is_trap),
        .ex_memread    (ex_memread),
        .ex_wreg       (ex_wreg),
        .ex_mispredict (ex_mispredict),
        .mem_busy      (mem_busy),
        .pc_keep       (pc_keep),
        .ifid_keep     (ifid_keep),
        .ifid_nop      (ifid_nop),
        .id_keep       (id_keep),
        .id_nop        (id_nop),
        .ex_keep       (ex_keep),
        .trap_redirect (trap_redirect),
        .state_o       (state_o),
        .stall_cnt     (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_wreg = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_is_csr = 1'b0; id_is_trap = 1'b0;
        ex_memread = 1'b0; ex_mispredict = 1'b0; mem_busy = 1'b0;
    endtask

    function automatic logic [31:0] exp_stalls();
`ifdef PIPE_STALL_CNT_EN
        return m_stalls;
`else
        return 32'h0;
`endif
    endfunction

    // One clock cycle: inputs already driven; check at negedge, advance model at posedge.
    task automatic cycle(input string tag);
        bit   hazard, hold_all, bubble, flush, redirect;
        int   n_phase, n_saved, n_left;
        bit   n_trap;
        logic [6:0] exp_o, obs_o;

        @(negedge clk);
        hazard = ex_memread && (ex_wreg != 0) &&
                 ((id_use_rs1 && id_rs1 == ex_wreg) || (id_use_rs2 && id_rs2 == ex_wreg));
        hold_all = 0; bubble = 0; flush = 0; redirect = 0;
        n_phase = m_phase; n_saved = m_saved; n_left = m_bubbles_left; n_trap = m_trap;

        if (m_phase == P_MWAIT) begin
            hold_all = 1;
            if (!mem_busy) n_phase = m_saved;
        end else if (mem_busy) begin
            hold_all = 1;
            n_saved  = m_phase;
            n_phase  = P_MWAIT;
        end else if (ex_mispredict && m_phase != P_REDIR) begin
            flush = 1; n_phase = P_RUN; n_left = 0; n_trap = 0;
        end else if (m_phase == P_RUN) begin
            if (id_is_csr) begin
                bubble  = 1;
                n_left  = (DC > 1) ? DC - 1 : 1;   // DRAIN cycles still to come
                n_trap  = id_is_trap;
                n_phase = P_DRAIN;
            end else if (hazard) begin
                bubble  = 1;
                n_phase = P_LDUSE;
            end
        end else if (m_phase == P_LDUSE) begin
            n_phase = P_RUN;
        end else if (m_phase == P_DRAIN) begin
            bubble  = 1;
            n_left  = m_bubbles_left - 1;
            n_phase = (n_left == 0) ? P_REDIR : P_DRAIN;
        end else begin
            redirect = m_trap;
            n_trap   = 0;
            n_phase  = P_RUN;
        end

        // {pc_keep, ifid_keep, ifid_nop, id_keep, id_nop, ex_keep, trap_redirect}
        exp_o = {hold_all | bubble, hold_all | bubble, flush | redirect,
                 hold_all, flush | bubble, hold_all, redirect};
        obs_o = {pc_keep, ifid_keep, ifid_nop, id_keep, id_nop, ex_keep, trap_redirect};
        check({tag, ".outs"}, 32'(obs_o), 32'(exp_o));
        check({tag, ".state"}, 32'(state_o), 32'(m_phase));
        check({tag, ".stall_cnt"}, stall_cnt, exp_stalls());
        check({tag, ".tr_twice"}, 32'(prev_tr & trap_redirect), 32'h0);
        prev_tr = trap_redirect;

        @(posedge clk);
        if (hold_all | bubble) m_stalls = m_stalls + 32'd1;
        m_phase = n_phase; m_saved = n_saved; m_bubbles_left = n_left; m_trap = n_trap;
        #1;
    endtask

    // Asynchronous reset pulse applied mid-cycle with inputs left as they are.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #2;
        check({tag, ".rst_outs"},
              32'({pc_keep, ifid_keep, ifid_nop, id_keep, id_nop, ex_keep, trap_redirect}), 32'h0);
        check({tag, ".rst_state"}, 32'(state_o), 32'h0);
        check({tag, ".rst_stall"}, stall_cnt, 32'h0);
        m_phase = P_RUN; m_saved = P_RUN; m_bubbles_left = 0; m_trap = 0;
        m_stalls = 32'h0; prev_tr = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        idle();
        m_phase = P_RUN; m_saved = P_RUN; m_bubbles_left = 0; m_trap = 0;
        m_stalls = 32'h0; prev_tr = 0;
        rst = 1'b0;
        #2;
        check("reset.outs",
              32'({pc_keep, ifid_keep, ifid_nop, id_keep, id_nop, ex_keep, trap_redirect}), 32'h0);
        check("reset.state", 32'(state_o), 32'h0);
        check("reset.stall", stall_cnt, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        cycle("idle");

        // lw x5 in EX, add x6,x5,x1 in ID: one stall cycle, LDUSE, RUN
        ex_memread = 1; ex_wreg = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1; id_rs2 = 5'd1; id_use_rs2 = 1;
        cycle("lu.stall");
        ex_memread = 0; ex_wreg = 5'd0;
        cycle("lu.ldUse");
        idle();
        cycle("lu.run");
        // load to x0 never stalls
        ex_memread = 1; ex_wreg = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
        cycle("lu.x0");
        // rs2-only hazard
        idle(); ex_memread = 1; ex_wreg = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1;
        cycle("lu.rs2");
        idle();
        cycle("lu.rs2.ldUse");

        // ecall: three bubbles, one redirect cycle, back to RUN
        id_is_csr = 1; id_is_trap = 1;
        cycle("ecall.b1"); cycle("ecall.b2"); cycle("ecall.b3");
        idle();
        cycle("ecall.redir");
        cycle("ecall.run");

        // csrrw draining, mispredict on second drain cycle aborts it
        id_is_csr = 1; id_is_trap = 0;
        cycle("csr.b1"); cycle("csr.b2");
        ex_mispredict = 1;
        cycle("csr.mispredict");
        idle();
        cycle("csr.after1"); cycle("csr.after2");

        // mem_busy for four cycles while DRAIN counter is 1
        id_is_csr = 1; id_is_trap = 1;
        cycle("mw.b1"); cycle("mw.b2");
        mem_busy = 1; ex_mispredict = 1;
        cycle("mw.busy1"); cycle("mw.busy2"); cycle("mw.busy3"); cycle("mw.busy4");
        mem_busy = 0; ex_mispredict = 0;
        cycle("mw.release");
        cycle("mw.drain");
        idle();
        cycle("mw.redir");
        cycle("mw.run");

        // reset mid-DRAIN: pending trap discarded
        id_is_csr = 1; id_is_trap = 1;
        cycle("rd.b1"); cycle("rd.b2");
        do_reset("rd");
        idle();
        cycle("rd.post1"); cycle("rd.post2"); cycle("rd.post3");

        // reset mid-MWAIT with mem_busy still high
        mem_busy = 1;
        cycle("rm.busy1"); cycle("rm.busy2");
        do_reset("rm");
        idle();
        cycle("rm.post1"); cycle("rm.post2");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rand");
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            ex_wreg       = 5'($urandom_range(0, 3));
            id_use_rs1    = 1'($urandom_range(0, 1));
            id_use_rs2    = 1'($urandom_range(0, 1));
            ex_memread    = 1'($urandom_range(0, 1));
            id_is_csr     = ($urandom_range(0, 5) == 0);
            id_is_trap    = 1'($urandom_range(0, 1));
            ex_mispredict = ($urandom_range(0, 6) == 0);
            mem_busy      = ($urandom_range(0, 5) == 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
